// File: rtl/mem_access_unit.sv
// Data-memory access unit: one load or store per request, word-aligned bus
// transaction with byte enables, lane replication on stores and lane extraction on loads.
module mem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  // state    | meaning
  // S_IDLE   | waiting for start; request inputs sampled here only
  // S_ACCESS | mem_req high, waiting for mem_ack or timeout
  // S_RESP   | done pulse for a completed or timed-out access
  // S_ERR    | done pulse for a rejected request, no bus activity
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP, S_ERR} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ALIGN   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  // Last counter value before the counter would reach TIMEOUT.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  err_q, err_d;

  logic        illegal;
  logic [3:0]  be_calc;
  logic [31:0] wd_calc;
  logic [31:0] load_ext;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    illegal = 1'b0;
    be_calc = 4'b0000;
    wd_calc = 32'h0;
    case (size)
      SZ_BYTE: begin
        be_calc = 4'b0001 << addr[1:0];
        wd_calc = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        illegal = addr[0];
        be_calc = 4'b0011 << {addr[1], 1'b0};
        wd_calc = {2{wdata[15:0]}};
      end
      SZ_WORD: begin
        illegal = (addr[1:0] != 2'b00);
        be_calc = 4'b1111;
        wd_calc = wdata;
      end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    rd_byte  = 8'h0;
    rd_half  = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_ext = mem_rdata;
    case (lane_q)
      2'd0:    rd_byte = mem_rdata[7:0];
      2'd1:    rd_byte = mem_rdata[15:8];
      2'd2:    rd_byte = mem_rdata[23:16];
      default: rd_byte = mem_rdata[31:24];
    endcase
    case (size_q)
      SZ_BYTE: load_ext = {{24{sign_q & rd_byte[7]}}, rd_byte};
      SZ_HALF: load_ext = {{16{sign_q & rd_half[15]}}, rd_half};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    sign_d  = sign_q;
    lane_d  = lane_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          we_d    = is_store;
          size_d  = size;
          sign_d  = sign;
          lane_d  = addr[1:0];
          addr_d  = {addr[31:2], 2'b00};
          be_d    = be_calc;
          wdata_d = wd_calc;
          cnt_d   = 8'd0;
          if (illegal) begin
            state_d = S_ERR;
            err_d   = ERR_ALIGN;
          end else begin
            state_d = S_ACCESS;
            err_d   = ERR_OK;
          end
        end
      end
      S_ACCESS: begin
        // An ack in the final allowed cycle wins over the timeout.
        if (mem_ack) begin
          state_d = S_RESP;
          err_d   = ERR_OK;
          if (!we_q) rdata_d = load_ext;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_RESP;
          err_d   = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      sign_q  <= 1'b0;
      lane_q  <= 2'b00;
      addr_q  <= 32'h0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      lane_q  <= lane_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_RESP) || (state_q == S_ERR);
  assign err       = done ? err_q : 2'b00;
  assign rdata     = rdata_q;
  assign mem_req   = (state_q == S_ACCESS);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with TIMEOUT = 4.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        is_store;
  logic [1:0]  size;
  logic        sign;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [1:0]  err;
  logic [31:0] rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int total = 0;
  int bad   = 0;

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store), .size(size),
    .sign(sign), .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
    .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Drive a request during one cycle; returns at cycle 1 (after the accepting edge).
  task automatic issue(input logic st, input logic [1:0] sz, input logic sg,
                       input logic [31:0] ad, input logic [31:0] wd);
    @(negedge clk);
    start = 1'b1; is_store = st; size = sz; sign = sg; addr = ad; wdata = wd;
    @(negedge clk);
    start = 1'b0; addr = 32'hDEAD_BEEF; wdata = 32'h5555_5555; size = 2'b11;
  endtask

  // Legal access acked in cycle 1: checks bus in cycle 1, done in cycle 2, idle in cycle 3.
  task automatic access(input string tag, input logic st, input logic [1:0] sz, input logic sg,
                        input logic [31:0] ad, input logic [31:0] wd, input logic [31:0] rd,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd,
                        input logic [31:0] exp_rd);
    issue(st, sz, sg, ad, wd);
    chk({tag, ".req"}, 32'(mem_req), 32'd1);
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    chk({tag, ".addr"}, mem_addr, {ad[31:2], 2'b00});
    chk({tag, ".be"}, 32'(mem_be), 32'(exp_be));
    chk({tag, ".we"}, 32'(mem_we), 32'(st));
    if (st) chk({tag, ".wdata"}, mem_wdata, exp_wd);
    mem_ack = 1'b1; mem_rdata = rd;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 32'h0;
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".req_off"}, 32'(mem_req), 32'd0);
    chk({tag, ".err"}, 32'(err), 32'd0);
    chk({tag, ".rdata"}, rdata, exp_rd);
    @(negedge clk);
    chk({tag, ".idle"}, 32'({busy, done}), 32'd0);
  endtask

  initial begin
    int n;
    int dones;
    rst_n = 1'b0; start = 1'b0; is_store = 1'b0; size = 2'b00; sign = 1'b0;
    addr = 32'h0; wdata = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.req", 32'(mem_req), 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    chk("rst.rdata", rdata, 32'h0);
    chk("rst.be", 32'(mem_be), 32'd0);
    chk("rst.addr", mem_addr, 32'h0);
    rst_n = 1'b1;

    access("lb",  1'b0, 2'b00, 1'b1, 32'h1003, 32'h0, 32'h80FF_1234, 4'b1000, 32'h0, 32'hFFFF_FF80);
    access("lhu", 1'b0, 2'b01, 1'b0, 32'h2002, 32'h0, 32'h8EF0_0004, 4'b1100, 32'h0, 32'h0000_8EF0);
    access("lh",  1'b0, 2'b01, 1'b1, 32'h2002, 32'h0, 32'h8EF0_0004, 4'b1100, 32'h0, 32'hFFFF_8EF0);
    access("lbu0",1'b0, 2'b00, 1'b0, 32'h0000, 32'h0, 32'h80FF_1234, 4'b0001, 32'h0, 32'h0000_0034);
    access("lb2", 1'b0, 2'b00, 1'b1, 32'h0002, 32'h0, 32'h80FF_1234, 4'b0100, 32'h0, 32'hFFFF_FFFF);
    access("lh0", 1'b0, 2'b01, 1'b1, 32'h0000, 32'h0, 32'h1234_7FFE, 4'b0011, 32'h0, 32'h0000_7FFE);
    access("lw",  1'b0, 2'b10, 1'b1, 32'h0004, 32'h0, 32'h8765_4321, 4'b1111, 32'h0, 32'h8765_4321);
    access("sb",  1'b1, 2'b00, 1'b0, 32'h0001, 32'h1234_56AB, 32'hFFFF_FFFF, 4'b0010, 32'hABAB_ABAB, 32'h8765_4321);
    access("sh",  1'b1, 2'b01, 1'b0, 32'h0002, 32'h0000_CAFE, 32'h0, 4'b1100, 32'hCAFE_CAFE, 32'h8765_4321);
    access("sw",  1'b1, 2'b10, 1'b0, 32'h0008, 32'hA5A5_0F0F, 32'h0, 4'b1111, 32'hA5A5_0F0F, 32'h8765_4321);

    // Illegal requests: done with err 01 in cycle 1, never a bus request.
    issue(1'b0, 2'b10, 1'b0, 32'h0006, 32'h0);
    chk("lw_mis.done", 32'(done), 32'd1);
    chk("lw_mis.err", 32'(err), 32'd1);
    chk("lw_mis.req", 32'(mem_req), 32'd0);
    @(negedge clk);
    chk("lw_mis.idle", 32'({busy, done, mem_req}), 32'd0);
    issue(1'b1, 2'b11, 1'b0, 32'h0000, 32'h0);
    chk("sz11.done", 32'(done), 32'd1);
    chk("sz11.err", 32'(err), 32'd1);
    chk("sz11.req", 32'(mem_req), 32'd0);
    issue(1'b0, 2'b01, 1'b0, 32'h0003, 32'h0);
    chk("lh_mis.err", 32'(err), 32'd1);
    chk("rdata_keep_err", rdata, 32'h8765_4321);
    @(negedge clk);

    // Timeout: exactly 4 request cycles, then err 10; a late ack is ignored.
    issue(1'b0, 2'b10, 1'b0, 32'h0040, 32'h0);
    n = 0;
    while (mem_req && n < 20) begin
      n++;
      chk("to.addr_stable", mem_addr, 32'h0040);
      @(negedge clk);
    end
    chk("to.req_cycles", 32'(n), 32'd4);
    chk("to.done", 32'(done), 32'd1);
    chk("to.err", 32'(err), 32'd2);
    chk("to.rdata", rdata, 32'h8765_4321);
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("late_ack.busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("late_ack.done", 32'(done), 32'd0);
    chk("late_ack.rdata", rdata, 32'h8765_4321);

    // Ack in the last allowed cycle still succeeds.
    issue(1'b0, 2'b10, 1'b0, 32'h0050, 32'h0);
    repeat (3) @(negedge clk);
    chk("edge.req4", 32'(mem_req), 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h2468_ACE0;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("edge.done", 32'(done), 32'd1);
    chk("edge.err", 32'(err), 32'd0);
    chk("edge.rdata", rdata, 32'h2468_ACE0);
    @(negedge clk);

    // Reset mid-access: everything clears, no done follows.
    issue(1'b1, 2'b10, 1'b0, 32'h0100, 32'hFFFF_FFFF);
    chk("rmid.req", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rmid.req0", 32'(mem_req), 32'd0);
    chk("rmid.busy", 32'(busy), 32'd0);
    chk("rmid.done", 32'(done), 32'd0);
    chk("rmid.bus", mem_addr | mem_wdata | 32'(mem_be) | 32'(mem_we), 32'h0);
    chk("rmid.rdata", rdata, 32'h0);
    dones = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("rmid.no_done", 32'(dones), 32'd0);

    // start while busy is dropped: exactly one done.
    issue(1'b0, 2'b00, 1'b0, 32'h0201, 32'h0);
    dones = 0;
    start = 1'b1; size = 2'b10; addr = 32'h0300;
    @(negedge clk);
    start = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h0000_9A00;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("bsy.rdata", rdata, 32'h0000_009A);
    repeat (8) begin
      if (done) dones++;
      @(negedge clk);
    end
    chk("bsy.one_done", 32'(dones), 32'd1);
    chk("bsy.idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
